// File: rtl/exp_pkg.sv
// Shared constants, ln(1+2^-i) table and FSM states for the
// shift-add log/exp datapaths (unsigned Q4.10).
package exp_pkg;
   localparam int W    = 14;
   localparam int FRAC = 10;
   localparam int NIDX = 11;

   localparam logic [W-1:0] YMAX = 14'd2838;
   localparam logic [W-1:0] ONE  = 14'(1 << FRAC);

   // ln(1+2^-i) in Q4.10, i = 0..10
   localparam logic [W-1:0] LN_TAB [NIDX] = '{
      14'd710, 14'd415, 14'd228, 14'd121, 14'd62, 14'd32,
      14'd16,  14'd8,   14'd4,   14'd2,   14'd1
   };

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;
endpackage

// File: rtl/exp_shift_add_if.sv
// Request/result bundle of the exponential unit.
interface exp_shift_add_if;
   import exp_pkg::*;

   logic         start;
   logic [W-1:0] y0;
   logic [W-1:0] xf;
   logic         busy;
   logic         done;
   logic         ovf;

   modport master (
      output start, y0,
      input  xf, busy, done, ovf
   );

   modport slave (
      input  start, y0,
      output xf, busy, done, ovf
   );
endinterface

// File: rtl/ln_const_rom.sv
// Combinational index -> ln(1+2^-i) lookup; 0 past the table end.
module ln_const_rom
   import exp_pkg::*;
(
   input  logic [3:0]   idx,
   output logic [W-1:0] val
);

   always_comb begin
      val = '0;
      if (int'(idx) < NIDX)
         val = LN_TAB[idx];
   end

endmodule

// File: rtl/exp_shift_add.sv
// Iterative shift-add e^y0: residual z walks down the ln table while
// x is scaled by (1+2^-i) for every constant subtracted.
module exp_shift_add
   import exp_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   exp_shift_add_if.slave bus
);

   state_t       state;
   logic [W-1:0] x;
   logic [W-1:0] z;
   logic [W-1:0] l;
   logic [3:0]   i;

   ln_const_rom u_rom (
      .idx (i),
      .val (l)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         x        <= '0;
         z        <= '0;
         i        <= '0;
         bus.xf   <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.y0 > YMAX) begin
                     bus.xf  <= '1;
                     bus.ovf <= 1'b1;
                     state   <= FIN;
                  end else begin
                     x        <= ONE;
                     z        <= bus.y0;
                     i        <= '0;
                     bus.ovf  <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               // stay on the same index until the constant no longer fits
               if (z >= l) begin
                  z <= z - l;
                  x <= x + (x >> i);
               end else if (i == 4'(NIDX - 1)) begin
                  state <= FIN;
               end else begin
                  i <= i + 4'd1;
               end
            end
            FIN: begin
               if (!bus.ovf)
                  bus.xf <= x;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
